// File: rtl/tick_timer.sv
// Programmable interval timer: counts rising edges of tick_in, raises a sticky
// interrupt on expiry, and runs one-shot or auto-reload.
module tick_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             irq_ack,
  output logic             irq,
  output logic             overrun,
  output logic             running,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_nxt_s;
  logic             tick_s_r;
  logic             tick_p_r;
  logic             tev_s;
  logic             expire_s;
  logic             irq_r;
  logic             irq_nxt_s;
  logic             overrun_r;
  logic             overrun_nxt_s;
  logic             running_r;
  logic             done_r;

  assign tev_s   = tick_s_r & ~tick_p_r;
  assign irq     = irq_r;
  assign overrun = overrun_r;
  assign running = running_r;
  assign done    = done_r;
  assign count   = count_r;

  // Next-state decode: load beats stop beats start; a tick during load is dropped.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    reload_nxt_s = reload_r;
    expire_s     = 1'b0;
    if (load) begin
      reload_nxt_s = period;
      count_nxt_s  = period;
    end else if (stop) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Count is kept so a stopped timer resumes where it left off.
          if (start && (reload_r != CNT_ZERO)) begin
            state_nxt_s = ST_RUN;
            if (count_r == CNT_ZERO) begin
              count_nxt_s = reload_r;
            end else begin
              count_nxt_s = count_r;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tev_s && (count_r > CNT_ONE)) begin
            count_nxt_s = count_r - CNT_ONE;
          end else if (tev_s && (count_r == CNT_ONE)) begin
            expire_s = 1'b1;
            if (auto_reload) begin
              count_nxt_s = reload_r;
            end else begin
              count_nxt_s = CNT_ZERO;
              state_nxt_s = ST_DONE;
            end
          end else begin
            count_nxt_s = count_r;
          end
        end
        ST_DONE: begin
          if (start && (reload_r != CNT_ZERO)) begin
            count_nxt_s = reload_r;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Interrupt flags: a fresh expiry wins over acknowledge for irq only.
  always_comb begin
    irq_nxt_s     = irq_r;
    overrun_nxt_s = overrun_r;
    if (expire_s) begin
      irq_nxt_s = 1'b1;
    end else if (irq_ack) begin
      irq_nxt_s = 1'b0;
    end else begin
      irq_nxt_s = irq_r;
    end
    if (irq_ack) begin
      overrun_nxt_s = 1'b0;
    end else if (expire_s && irq_r) begin
      overrun_nxt_s = 1'b1;
    end else begin
      overrun_nxt_s = overrun_r;
    end
  end

  // All timer state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      reload_r  <= CNT_ZERO;
      tick_s_r  <= 1'b0;
      tick_p_r  <= 1'b0;
      irq_r     <= 1'b0;
      overrun_r <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      tick_s_r  <= tick_in;
      tick_p_r  <= tick_s_r;
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      reload_r  <= reload_nxt_s;
      irq_r     <= irq_nxt_s;
      overrun_r <= overrun_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Scenario bench for tick_timer: expected status snapshots are queued with each
// stimulus step and compared against captured DUT snapshots.
module tb_tick_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        load = 1'b0;
  logic [31:0] period = 32'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        auto_reload = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq;
  logic        overrun;
  logic        running;
  logic        done;
  logic [31:0] count;

  int total = 0;
  int bad   = 0;

  // {count, irq, overrun, running, done}
  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];

  tick_timer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .load(load), .period(period),
    .start(start), .stop(stop), .auto_reload(auto_reload), .irq_ack(irq_ack),
    .irq(irq), .overrun(overrun), .running(running), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic snap(input logic [31:0] c, input logic i, input logic o,
                      input logic r, input logic d);
    exp_q.push_back({c, i, o, r, d});
    obs_q.push_back({count, irq, overrun, running, done});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] p);
    @(negedge clk); load = 1'b1; period = p;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk); tick_in = 1'b1;
    cyc(4);
    tick_in = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    logic [35:0] e, o;
    int k = 0;
    tick_in = 1'b1;
    #1 rst = 1'b0;
    #1 snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    rst = 1'b1;
    cyc(5);
    snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_in = 1'b0;
    cyc(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset[%0d]: got=%h want=%h (count,irq,ovr,run,done)", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_oneshot();
    logic [35:0] e, o;
    int k = 0;
    auto_reload = 1'b0;
    do_load(32'd3);
    snap(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start();
    snap(32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); snap(32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); snap(32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(2); tick_in = 1'b0; cyc(2);
    do_tick(); snap(32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_ack();  snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL oneshot[%0d]: got=%h want=%h (count,irq,ovr,run,done)", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_autoreload();
    logic [35:0] e, o;
    int k = 0;
    auto_reload = 1'b1;
    do_load(32'd2);
    do_start();
    snap(32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    do_ack();  snap(32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    do_stop(); snap(32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    do_ack();  snap(32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL autoreload[%0d]: got=%h want=%h (count,irq,ovr,run,done)", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_ack_collide();
    logic [35:0] e, o;
    int k = 0;
    auto_reload = 1'b1;
    do_load(32'd1);
    do_start();
    do_tick(); snap(32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    // Ack lands on the same edge as the second expiry.
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
    snap(32'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(2); tick_in = 1'b0; cyc(2);
    do_ack();  snap(32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_stop(); snap(32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL ack_collide[%0d]: got=%h want=%h (count,irq,ovr,run,done)", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_stop_resume();
    logic [35:0] e, o;
    int k = 0;
    auto_reload = 1'b0;
    do_load(32'd5);
    do_start();
    do_tick(); do_tick();
    snap(32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_stop(); snap(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(); snap(32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    do_start(); snap(32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick();  snap(32'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick();  snap(32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick();  snap(32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_ack();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL stop_resume[%0d]: got=%h want=%h (count,irq,ovr,run,done)", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_edges();
    logic [35:0] e, o;
    int k = 0;
    auto_reload = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    do_start(); snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_load(32'd4);
    do_start();
    do_tick(); snap(32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    // Load on the same edge as the tick event: the tick is lost.
    @(negedge clk); tick_in = 1'b1;
    @(negedge clk); load = 1'b1; period = 32'd7;
    @(negedge clk); load = 1'b0;
    snap(32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(2); tick_in = 1'b0; cyc(2);
    snap(32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(); snap(32'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    // Asynchronous reset mid-interval, observed before any clock edge.
    @(posedge clk); #2 rst = 1'b0;
    #1 snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    do_start(); snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_tick();  snap(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin
        bad++;
        $display("FAIL edges[%0d]: got=%h want=%h (count,irq,ovr,run,done)", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_ack_collide();
    test_stop_resume();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
# tick_timer

Programmable interval timer driven by the one-clock-domain tick pulses of the countdown pulse generator: it counts rising edges of `tick_in`, raises a sticky interrupt request when a programmed number of ticks has elapsed, and runs either one-shot or auto-reload. It sits directly downstream of the generator and turns its raw pulse train into software-visible timing events with a request/acknowledge handshake.

## Interface

- `WIDTH`, 32, width of period and count registers.

- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `tick_in`  input  1  pulse from generator output; level may stay high for several `clk` cycles.
- `load`  input  1  one-cycle strobe: capture `period` into reload register and count.
- `period`  input  WIDTH  tick count per interval; sampled only when `load`=1.
- `start`  input  1  one-cycle strobe: begin counting.
- `stop`  input  1  one-cycle strobe: halt counting, count held.
- `auto_reload`  input  1  1 = reload and continue on expiry; 0 = one-shot. Sampled at expiry.
- `irq_ack`  input  1  one-cycle strobe: clear `irq` and `overrun`.
- `irq`  output  1  sticky expiry request.
- `overrun`  output  1  sticky: expiry occurred while `irq` already pending.
- `running`  output  1  state is RUN.
- `done`  output  1  state is DONE (one-shot expired).
- `count`  output  WIDTH  remaining ticks in current interval.

## Operation

- Tick detection: `tick_s` register samples `tick_in`; `tick_p` register samples `tick_s`; tick event `tev = tick_s & ~tick_p`. One event per rising edge of `tick_in` regardless of high duration.
- States: IDLE, RUN, DONE. All outputs registered.
- Command priority each cycle: `load` > `stop` > `start`.
- `load` (any state): reload_reg <= `period`, `count` <= `period`; state unchanged; a `tev` in the same cycle is discarded.
- IDLE: `start` with reload_reg != 0 -> RUN (count unchanged, so a stopped timer resumes). `start` with reload_reg == 0 ignored. If count == 0 and reload_reg != 0, `start` also sets count <= reload_reg.
- RUN: `stop` -> IDLE, count held. `start` ignored. On `tev`: if count > 1, count <= count-1; if count == 1 (expiry): set `irq`; `auto_reload`=1 -> count <= reload_reg, stay RUN; `auto_reload`=0 -> count <= 0, go DONE.
- DONE: `start` (reload_reg != 0) -> count <= reload_reg, RUN. `stop` -> IDLE. `tev` ignored.
- `tev` ignored in IDLE and DONE.
- irq/overrun: expiry with `irq`=1 and no `irq_ack` that cycle sets `overrun`. `irq_ack` clears both. Expiry coinciding with `irq_ack`: `irq` = 1 (set wins), `overrun` = 0.
- Arithmetic: count is unsigned WIDTH bits; never decremented below 1 in RUN, so no wrap-around. `period` = 1 expires on every tick.

## Timing

- Reset (`rst`=0, immediate, no clock needed): state IDLE, count 0, reload_reg 0, `tick_s`/`tick_p` 0, `irq` 0, `overrun` 0, `running` 0, `done` 0.
- Tick latency: `tick_in` high before edge N -> `tick_s`=1 after N -> count update, `irq` set, state change visible after edge N+1 (2-cycle latency).
- `load`/`start`/`stop`/`irq_ack` take effect on the edge where sampled high; outputs reflect it after that edge (1-cycle latency).
- Reset asserted mid-interval: everything returns to reset values; reload_reg must be reloaded before next `start`.
- `tick_in` held high across reset release: `tick_p`=0 may produce one `tev`, harmless since state is IDLE.
- Minimum `tick_in` low time between pulses: 1 `clk` cycle (sampled), else edges merge.

## Test plan

- Reset with `tick_in`=1, all strobes 0 -> all outputs 0, state IDLE; no count change after 5 cycles.
- `load` period=3, `start`, auto_reload=0, 3 ticks each 4 cycles high -> count 3,2,1,0; `irq`=1 and `done`=1 two cycles after third tick rises; 4th tick no effect.
- period=2, auto_reload=1, 6 ticks, `irq_ack` after 2nd tick only -> expiries at ticks 2,4,6; `overrun`=1 after tick 6; count returns to 2 after each expiry.
- Expiry in same cycle as `irq_ack` -> `irq`=1, `overrun`=0.
- period=5, 2 ticks, `stop`, 3 ticks, `start`, 3 ticks -> count 3 held while IDLE, expiry on 3rd tick after restart.
- `start` with reload_reg=0 -> stays IDLE; `load` coincident with `tev` in RUN -> count = new `period`, tick lost.
